vend_sequencer: RTL
===================

# vend_sequencer

Sequencing controller placed between the coin-credit accumulator and the product dispense mechanism. It checks credit against the price, arbitrates between simultaneous soda and diet selections, and drives a request/acknowledge handshake to the dispenser. It then pays out change one nickel at a time and clears the accumulator.

## Interface
- `PRICE`, 45, product price in cents; multiple of 5, ≤ 127
- `TIMEOUT_CYC`, 16, cycles to wait for `vend_ack` before faulting (used only with `VEND_TIMEOUT_EN`)
- `CLK`  in  1  rising-edge clock, the only clock
- `reset`  in  1  asynchronous, active-high reset
- `credit`  in  7  current credit in cents from the accumulator; always a multiple of 5
- `soda`  in  1  soda selection request (level)
- `diet`  in  1  diet selection request (level)
- `stock_soda`  in  1  1 = soda available
- `stock_diet`  in  1  1 = diet available
- `vend_ack`  in  1  dispenser done; 1-cycle pulse or level
- `GiveSoda`  out  1  soda dispense request, held until ack
- `GiveDiet`  out  1  diet dispense request, held until ack
- `change_pulse`  out  1  one high cycle per nickel returned
- `credit_clr`  out  1  1-cycle pulse that zeroes the accumulator
- `busy`  out  1  high in every state except IDLE
- `fault`  out  1  sticky dispense-timeout flag

## Operation
- States: IDLE, VEND, CHANGE, CLEAR, plus REFUND with `VEND_TIMEOUT_EN`.
- **IDLE.**
  - A selection is eligible if its request and stock bits are both 1 and `credit >= PRICE`.
  - If any selection is eligible, latch the selection and `chg = (credit - PRICE)/5` (7-bit nickel count), latch `credit`, and go to VEND.
- **Arbitration.** When soda and diet are both eligible in the same cycle, the one not served last wins. The priority bit resets to "soda first" and updates only on entry to VEND.
- **VEND.**
  - Assert `GiveSoda` or `GiveDiet` (never both).
  - On `vend_ack`=1, go to CHANGE; `Give*` drops in the same edge.
  - `vend_ack` in any other state is ignored.
- **CHANGE.**
  - If `chg`=0, go to CLEAR.
  - Otherwise alternate `change_pulse` high 1 cycle, low 1 cycle, decrementing `chg` on each high cycle. Go to CLEAR after the low cycle that follows the last pulse.
- **CLEAR.** `credit_clr`=1 for exactly one cycle, then IDLE.
- **Ignored inputs.** Selections and `credit` changes outside IDLE are ignored; they are sampled only in IDLE.
- **Insufficient credit or empty stock.** Stay in IDLE and produce no outputs.
- **Reset** at any time, including mid-VEND or mid-CHANGE:
  - state = IDLE, priority = soda, `chg`=0.
  - All outputs 0, including `fault`.
  - No partial change is completed.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Selection sampled eligible at edge N: `GiveX`=1 and `busy`=1 after edge N.
- `vend_ack` sampled at edge M: `GiveX`=0 after edge M. The first `change_pulse` is high after edge M+1 if `chg`>0.
- k nickels of change occupy 2k cycles in CHANGE. `credit_clr` is high in the cycle after CHANGE exits. `busy` falls with the return to IDLE one cycle later.
- Minimum transaction with exact credit and ack on the first VEND cycle:
  - IDLE → VEND → CHANGE → CLEAR → IDLE.
  - `busy` is high for 3 cycles.
- Reset values: `GiveSoda`=0, `GiveDiet`=0, `change_pulse`=0, `credit_clr`=0, `busy`=0, `fault`=0.

## Configuration
- Macro: `VEND_TIMEOUT_EN`.
- **Defined.**
  - A counter runs in VEND.
  - If `vend_ack` has not been seen after `TIMEOUT_CYC` cycles in VEND: drop `Give*`, set `fault`=1 (sticky until reset), load `chg = latched credit/5`, and go to REFUND.
  - REFUND pulses exactly as CHANGE does, then goes to CLEAR.
  - The priority bit is still updated.
  - An ack arriving in the same cycle the count expires wins: normal CHANGE path.
- **Undefined.** VEND waits indefinitely for `vend_ack`; REFUND, the counter and `TIMEOUT_CYC` are absent, and `fault` is tied 0.

## Test plan
- credit=45, soda=1, stock_soda=1, ack 3 cycles later → `GiveSoda` high 3 cycles, no `change_pulse`, one `credit_clr`, `busy` back to 0.
- credit=60, diet=1, ack → `GiveDiet`, then exactly 3 `change_pulse` high cycles spaced 1 low, then `credit_clr`.
- soda=diet=1 held, credit=45, three back-to-back transactions → served soda, diet, soda.
- credit=40 with soda=1, or credit=100 with soda=1 and stock_soda=0 → stays IDLE, all outputs 0.
- Reset asserted mid-CHANGE after 1 of 4 pulses → all outputs 0 immediately; no further pulses, no `credit_clr`.
- With `VEND_TIMEOUT_EN`, TIMEOUT_CYC=16, credit=50, no ack → `GiveX` drops after 16 cycles, `fault`=1, 10 `change_pulse`s, `credit_clr`; `fault` stays 1 until reset.

Source files
------------

// File: rtl/vend_sequencer.sv
// Vend sequencer: credit check, soda/diet arbitration, dispense handshake,
// nickel-by-nickel change and accumulator clear. Define VEND_TIMEOUT_EN for dispense timeout with refund.
module vend_sequencer #(
  parameter int PRICE = 45
`ifdef VEND_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 16
`endif
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [6:0] credit,
  input  logic       soda,
  input  logic       diet,
  input  logic       stock_soda,
  input  logic       stock_diet,
  input  logic       vend_ack,
  output logic       GiveSoda,
  output logic       GiveDiet,
  output logic       change_pulse,
  output logic       credit_clr,
  output logic       busy,
  output logic       fault
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VEND   = 3'd1;
  localparam logic [2:0] ST_CHANGE = 3'd2;
  localparam logic [2:0] ST_CLEAR  = 3'd3;
`ifdef VEND_TIMEOUT_EN
  localparam logic [2:0]  ST_REFUND = 3'd4;
  localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT_CYC - 1);
`endif
  localparam logic [6:0] PRICE_C = 7'(PRICE);

  logic [2:0] state_q, state_d;
  logic       prio_q, prio_d;
  logic [6:0] chg_q, chg_d;
  logic       phase_q, phase_d;
  logic       give_soda_q, give_soda_d;
  logic       give_diet_q, give_diet_d;
  logic       pulse_q, pulse_d;
  logic       clr_q, clr_d;
  logic       busy_q, busy_d;
`ifdef VEND_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic [6:0]  credit_q, credit_d;
`endif

  logic elig_soda_s;
  logic elig_diet_s;
  logic pick_soda_s;

  // Eligibility and arbitration; prio_q = 1 means diet goes first on a tie.
  always_comb begin
    elig_soda_s = soda & stock_soda & (credit >= PRICE_C);
    elig_diet_s = diet & stock_diet & (credit >= PRICE_C);
    pick_soda_s = elig_soda_s & (~elig_diet_s | ~prio_q);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    chg_d       = chg_q;
    phase_d     = phase_q;
    give_soda_d = give_soda_q;
    give_diet_d = give_diet_q;
    pulse_d     = 1'b0;
    clr_d       = 1'b0;
`ifdef VEND_TIMEOUT_EN
    cnt_d       = cnt_q;
    fault_d     = fault_q;
    credit_d    = credit_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (elig_soda_s | elig_diet_s) begin
          state_d     = ST_VEND;
          give_soda_d = pick_soda_s;
          give_diet_d = ~pick_soda_s;
          prio_d      = pick_soda_s;
          chg_d       = (credit - PRICE_C) / 7'd5;
          phase_d     = 1'b0;
`ifdef VEND_TIMEOUT_EN
          cnt_d       = 16'd0;
          credit_d    = credit;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VEND: begin
        if (vend_ack) begin
          state_d     = ST_CHANGE;
          give_soda_d = 1'b0;
          give_diet_d = 1'b0;
          phase_d     = 1'b0;
        end
`ifdef VEND_TIMEOUT_EN
        // An ack in the expiry cycle takes the branch above.
        else if (cnt_q == CNT_LAST) begin
          state_d     = ST_REFUND;
          give_soda_d = 1'b0;
          give_diet_d = 1'b0;
          phase_d     = 1'b0;
          fault_d     = 1'b1;
          chg_d       = credit_q / 7'd5;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`else
        else begin
          state_d = ST_VEND;
        end
`endif
      end
`ifdef VEND_TIMEOUT_EN
      ST_CHANGE, ST_REFUND: begin
`else
      ST_CHANGE: begin
`endif
        // phase_q marks the cycle in which the pulse is visible.
        if (phase_q) begin
          phase_d = 1'b0;
          if (chg_q == 7'd0) begin
            state_d = ST_CLEAR;
            clr_d   = 1'b1;
          end else begin
            state_d = state_q;
          end
        end else if (chg_q == 7'd0) begin
          state_d = ST_CLEAR;
          clr_d   = 1'b1;
        end else begin
          pulse_d = 1'b1;
          chg_d   = chg_q - 7'd1;
          phase_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        give_soda_d = 1'b0;
        give_diet_d = 1'b0;
        chg_d       = 7'd0;
        phase_d     = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      chg_q       <= 7'd0;
      phase_q     <= 1'b0;
      give_soda_q <= 1'b0;
      give_diet_q <= 1'b0;
      pulse_q     <= 1'b0;
      clr_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      cnt_q       <= 16'd0;
      fault_q     <= 1'b0;
      credit_q    <= 7'd0;
`endif
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      chg_q       <= chg_d;
      phase_q     <= phase_d;
      give_soda_q <= give_soda_d;
      give_diet_q <= give_diet_d;
      pulse_q     <= pulse_d;
      clr_q       <= clr_d;
      busy_q      <= busy_d;
`ifdef VEND_TIMEOUT_EN
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
      credit_q    <= credit_d;
`endif
    end
  end

  assign GiveSoda     = give_soda_q;
  assign GiveDiet     = give_diet_q;
  assign change_pulse = pulse_q;
  assign credit_clr   = clr_q;
  assign busy         = busy_q;
`ifdef VEND_TIMEOUT_EN
  assign fault        = fault_q;
`else
  assign fault        = 1'b0;
`endif

endmodule
